// File: rtl/dense_argmax_pkg.sv
// dense_argmax_pkg: shared FSM states, index width and data-width helper for dense_argmax
package dense_argmax_pkg;
  localparam int IDX_W = 7;
  typedef enum logic [2:0] {IDLE, WAIT, COMPARE, NEXT, DONE} state_t;
  function automatic int data_w(input int integer_width, input int fraction_width);
    return integer_width + fraction_width;
  endfunction
endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker: running signed maximum (and runner-up when ARGMAX_TOP2_EN is defined)
// Ports: clk, reset (async, active-high); valid strobes one sample; first marks index 0;
// idx/sample are the candidate; best_idx/best_val (and second_idx/second_val) hold the leaders.
module argmax_tracker
  import dense_argmax_pkg::*;
#(
  parameter int DW = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 first,
  input  logic [IDX_W-1:0]     idx,
  input  logic signed [DW-1:0] sample,
  output logic [IDX_W-1:0]     best_idx,
  output logic signed [DW-1:0] best_val
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]     second_idx,
  output logic signed [DW-1:0] second_val
`endif
);
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic signed [DW-1:0] best_val_q, best_val_d;
  logic take_best;
  // strict greater-than keeps the lower index on ties
  always_comb begin
    take_best = valid && (first || sample > best_val_q);
    best_idx_d = take_best ? idx : best_idx_q;
    best_val_d = take_best ? sample : best_val_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  assign best_idx = best_idx_q;
  assign best_val = best_val_q;
`ifdef ARGMAX_TOP2_EN
  logic [IDX_W-1:0] second_idx_q, second_idx_d;
  logic signed [DW-1:0] second_val_q, second_val_d;
  logic shift, fill;
  // index 1 fills the empty runner-up slot unconditionally unless it displaces best
  always_comb begin
    shift = valid && !first && sample > best_val_q;
    fill = valid && !first && !shift && (idx == IDX_W'(1) || sample > second_val_q);
    second_idx_d = shift ? best_idx_q : fill ? idx : second_idx_q;
    second_val_d = shift ? best_val_q : fill ? sample : second_val_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      second_idx_q <= '0;
      second_val_q <= '0;
    end else begin
      second_idx_q <= second_idx_d;
      second_val_q <= second_val_d;
    end
  assign second_idx = second_idx_q;
  assign second_val = second_val_q;
`endif
endmodule

// File: rtl/dense_argmax.sv
// dense_argmax: scans the dense-layer output BRAM and reports the signed argmax
// Ports: clk, reset (async, active-high), enableOperation (level start);
// dense_output_address/enable/data form the BRAM read port; class_index/class_value
// hold the winner and change only with done, which stays high until reset.
// Optional: ARGMAX_TOP2_EN adds second_index/second_value for the runner-up.
module dense_argmax
  import dense_argmax_pkg::*;
#(
  parameter int NEURON = 100,
  parameter int INTEGER_WIDTH = 10,
  parameter int FRACTION_WIDTH = 10,
  parameter int READ_LATENCY = 2,
  localparam int DW = data_w(INTEGER_WIDTH, FRACTION_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enableOperation,
  output logic [IDX_W-1:0]     dense_output_address,
  output logic                 dense_output_enable,
  input  logic signed [DW-1:0] dense_output_data,
  output logic [IDX_W-1:0]     class_index,
  output logic signed [DW-1:0] class_value,
  output logic                 done
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]     second_index,
  output logic signed [DW-1:0] second_value
`endif
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURON - 1);
  localparam logic [3:0] CNT_LAST = 4'(READ_LATENCY - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] addr_q, addr_d, cidx_q, cidx_d, best_idx;
  logic en_q, en_d, done_q, done_d;
  logic signed [DW-1:0] cval_q, cval_d, best_val;
`ifdef ARGMAX_TOP2_EN
  logic [IDX_W-1:0] sidx_q, sidx_d, sec_idx;
  logic signed [DW-1:0] sval_q, sval_d, sec_val;
`endif
  argmax_tracker #(.DW(DW)) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .valid    (state_q == COMPARE),
    .first    (addr_q == '0),
    .idx      (addr_q),
    .sample   (dense_output_data),
    .best_idx (best_idx),
    .best_val (best_val)
`ifdef ARGMAX_TOP2_EN
    ,
    .second_idx (sec_idx),
    .second_val (sec_val)
`endif
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    en_d = en_q;
    done_d = done_q;
    cidx_d = cidx_q;
    cval_d = cval_q;
`ifdef ARGMAX_TOP2_EN
    sidx_d = sidx_q;
    sval_d = sval_q;
`endif
    case (state_q)
      IDLE: if (enableOperation) begin
        addr_d = '0;
        en_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q == CNT_LAST ? '0 : cnt_q + 4'd1;
        state_d = cnt_q == CNT_LAST ? COMPARE : WAIT;
      end
      COMPARE: state_d = NEXT;
      NEXT: if (addr_q != LAST) begin
        addr_d = addr_q + 1'b1;
        state_d = WAIT;
      end else begin
        en_d = 1'b0;
        done_d = 1'b1;
        cidx_d = best_idx;
        cval_d = best_val;
`ifdef ARGMAX_TOP2_EN
        sidx_d = sec_idx;
        sval_d = sec_val;
`endif
        state_d = DONE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      cidx_q <= '0;
      cval_q <= '0;
`ifdef ARGMAX_TOP2_EN
      sidx_q <= '0;
      sval_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      en_q <= en_d;
      done_q <= done_d;
      cidx_q <= cidx_d;
      cval_q <= cval_d;
`ifdef ARGMAX_TOP2_EN
      sidx_q <= sidx_d;
      sval_q <= sval_d;
`endif
    end
  assign dense_output_address = addr_q;
  assign dense_output_enable = en_q;
  assign class_index = cidx_q;
  assign class_value = cval_q;
  assign done = done_q;
`ifdef ARGMAX_TOP2_EN
  assign second_index = sidx_q;
  assign second_value = sval_q;
`endif
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: directed bench for dense_argmax (default instance plus NEURON=1/READ_LATENCY=1 instance)
module tb_dense_argmax;
  localparam int DW = 20;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, en_s = 1'b0;
  always #5 clk = ~clk;
  logic [6:0] addr, addr_s, cidx, cidx_s;
  logic den, den_s, done, done_s;
  logic [DW-1:0] data, data_s, cval, cval_s;
`ifdef ARGMAX_TOP2_EN
  logic [6:0] sidx, sidx_s;
  logic [DW-1:0] sval, sval_s;
`endif
  logic [DW-1:0] mem [128];
  logic [DW-1:0] p0, p1, q0;
  int n_cmp = 0, n_bad = 0, lat;

  // BRAM models: two-stage read pipe for the default instance, one stage for the small one
  always @(posedge clk) begin
    if (den) p0 <= mem[addr];
    p1 <= p0;
    if (den_s) q0 <= (addr_s == 7'd0) ? 20'h00400 : 20'h0;
  end
  assign data = p1;
  assign data_s = q0;

  dense_argmax dut (
    .clk(clk), .reset(reset), .enableOperation(en),
    .dense_output_address(addr), .dense_output_enable(den), .dense_output_data(data),
    .class_index(cidx), .class_value(cval), .done(done)
`ifdef ARGMAX_TOP2_EN
    , .second_index(sidx), .second_value(sval)
`endif
  );

  dense_argmax #(.NEURON(1), .READ_LATENCY(1)) dut_s (
    .clk(clk), .reset(reset), .enableOperation(en_s),
    .dense_output_address(addr_s), .dense_output_enable(den_s), .dense_output_data(data_s),
    .class_index(cidx_s), .class_value(cval_s), .done(done_s)
`ifdef ARGMAX_TOP2_EN
    , .second_index(sidx_s), .second_value(sval_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int k = 0; k < 128; k++) mem[k] = v;
  endtask

  task automatic ramp();
    for (int k = 0; k < 128; k++) mem[k] = 20'(k * 1024);
  endtask

  // pulse enableOperation for one edge (E0) and count edges until done is seen
  task automatic scan(output int n);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    ramp();
    repeat (2) @(negedge clk);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_en", 32'(den), 0);
    chk("rst_idx", 32'(cidx), 0);
    chk("rst_val", 32'(cval), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_s", 32'(done_s), 0);
    reset = 1'b0;
    // ramp: largest at the last entry
    scan(lat);
    chk("ramp_lat", 32'(lat), 400);
    chk("ramp_idx", 32'(cidx), 99);
    chk("ramp_val", 32'(cval), 32'h18C00);
    chk("ramp_en_off", 32'(den), 0);
    // DONE ignores a new start
    @(negedge clk); en = 1'b1;
    repeat (5) @(negedge clk);
    chk("done_hold", 32'(done), 1);
    chk("done_idx", 32'(cidx), 99);
    chk("done_en", 32'(den), 0);
    en = 1'b0;
    // tie goes to the lower index
    do_reset();
    fill(20'h0); mem[37] = 20'h00E00; mem[80] = 20'h00E00;
    scan(lat);
    chk("tie_lat", 32'(lat), 400);
    chk("tie_idx", 32'(cidx), 37);
    chk("tie_val", 32'(cval), 32'h00E00);
    // all negative: signed compare
    do_reset();
    fill(20'hFFC00); mem[5] = 20'hFFE00;
    scan(lat);
    chk("neg_idx", 32'(cidx), 5);
    chk("neg_val", 32'(cval), 32'hFFE00);
    // reset at E0+150, then a fresh scan
    do_reset();
    ramp();
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("mid_addr", 32'(addr), 37);
    chk("mid_en", 32'(den), 1);
    chk("mid_done", 32'(done), 0);
    reset = 1'b1;
    #1;
    chk("arst_addr", 32'(addr), 0);
    chk("arst_en", 32'(den), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_idx", 32'(cidx), 0);
    chk("arst_val", 32'(cval), 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_en", 32'(den), 0);
    scan(lat);
    chk("rescan_lat", 32'(lat), 400);
    chk("rescan_idx", 32'(cidx), 99);
    chk("rescan_val", 32'(cval), 32'h18C00);
    // NEURON=1, READ_LATENCY=1 instance
    @(negedge clk); en_s = 1'b1;
    @(posedge clk); #1 en_s = 1'b0;
    lat = 0;
    while (done_s !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("one_lat", 32'(lat), 3);
    chk("one_idx", 32'(cidx_s), 0);
    chk("one_val", 32'(cval_s), 32'h00400);
    chk("one_en_off", 32'(den_s), 0);
`ifdef ARGMAX_TOP2_EN
    chk("one_sec_idx", 32'(sidx_s), 0);
    chk("one_sec_val", 32'(sval_s), 0);
`endif
    // three peaks: winner and runner-up
    do_reset();
    fill(20'h0); mem[10] = 20'h00800; mem[20] = 20'h00C00; mem[30] = 20'h00A00;
    scan(lat);
    chk("top_lat", 32'(lat), 400);
    chk("top_idx", 32'(cidx), 20);
    chk("top_val", 32'(cval), 32'h00C00);
`ifdef ARGMAX_TOP2_EN
    chk("sec_idx", 32'(sidx), 30);
    chk("sec_val", 32'(sval), 32'h00A00);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dense_argmax.md
# dense_argmax

Classification stage directly downstream of the decoder dense layer. Once the dense layer asserts its done flag, this block scans the dense layer's NEURON-entry ReLU output BRAM through that layer's read port (address, enable, data). It tracks the signed maximum and reports the winning neuron index and its value, then asserts done.

## Interface
- NEURON, 100: number of dense outputs to scan (1..128).
- INTEGER_WIDTH, 10: integer bits of the fixed-point data.
- FRACTION_WIDTH, 10: fraction bits of the fixed-point data.
- READ_LATENCY, 2: cycles from an address change to valid `dense_output_data` (1..15).
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- enableOperation  input  1  level start; tied to the dense layer's done.
- dense_output_address  output  7  read address into the dense output BRAM.
- dense_output_enable  output  1  read enable into the dense output BRAM.
- dense_output_data  input  INTEGER_WIDTH+FRACTION_WIDTH  two's-complement Q(INTEGER_WIDTH.FRACTION_WIDTH) read data.
- class_index  output  7  index of the maximum entry.
- class_value  output  INTEGER_WIDTH+FRACTION_WIDTH  value of the maximum entry.
- done  output  1  results valid; held high until reset.

## Operation
- Reset values: address 0, enable 0, class_index 0, class_value 0, done 0, state IDLE, delay counter 0.
- IDLE: if enableOperation=1, set address to 0 and enable to 1, then go to WAIT. Otherwise stay in IDLE.
- WAIT: hold the address for READ_LATENCY cycles using a delay counter, then go to COMPARE and clear the counter.
- COMPARE: sample dense_output_data.
  - At index 0, the sample loads best unconditionally.
  - At later indices, best updates only on a strictly greater signed value, so on a tie the lower index wins.
  - Go to NEXT.
- NEXT:
  - If address < NEURON-1, increment the address and go to WAIT.
  - Otherwise drive enable to 0, copy best to class_index/class_value, set done=1, and go to DONE.
- DONE: terminal state. Outputs are frozen and enableOperation is ignored. Only reset leaves DONE.
- Arithmetic: signed compare at full width. No saturation or rounding; values pass through bit-exact.
- Boundaries:
  - enableOperation deasserted mid-scan: ignored, the scan completes.
  - reset mid-scan: everything clears within the same cycle; the scan restarts only from IDLE.
  - All entries equal: class_index=0.
  - NEURON=1: a single element is scanned, and done follows the first NEXT.
- class_index and class_value are not updated during the scan. They change only together with done.

## Timing
- Edge E0 samples enableOperation=1 in IDLE.
- Each element takes READ_LATENCY+2 cycles: READ_LATENCY cycles of WAIT, one COMPARE, one NEXT.
- done rises on edge E0 + NEURON*(READ_LATENCY+2). With the defaults that is E0+400.
- The address is stable from its update edge through COMPARE. Data is sampled READ_LATENCY+1 edges after the address changes.
- dense_output_enable is high from E0+1 through the final NEXT edge.

## Configuration
- ARGMAX_TOP2_EN defined: adds outputs second_index (7) and second_value (data width), with reset value 0.
  - Index 0 loads best.
  - Index 1 loads second if it is not greater than best. Otherwise best moves to second and the new sample becomes best.
  - Later samples: if greater than best, best moves to second and the new sample becomes best; else if strictly greater than second, the sample replaces second.
  - With NEURON=1, second stays at 0.
- ARGMAX_TOP2_EN undefined: the second_* ports and registers do not exist. Top-1 behaviour is identical in both builds.

## Structure
- Package dense_argmax_pkg holds:
  - the state localparams (IDLE, WAIT, COMPARE, NEXT, DONE);
  - the index width constant (7);
  - the data width expression INTEGER_WIDTH+FRACTION_WIDTH.
- One sub-module, argmax_tracker, holds the best/second registers and the compare-update logic. It takes a sample, an index, a valid strobe and a first flag. The second slot is compiled inside it under ARGMAX_TOP2_EN.
- The top level holds the FSM, the delay counter and the address generation.

## Test plan
- Defaults; memory holds entry k = k*0x400 (values 0.0..99.0); pulse enableOperation -> done at E0+400, class_index=99, class_value=0x18C00.
- Entry 37=0x00E00 (3.5); all others 0; entry 80=0x00E00 -> class_index=37 (tie goes to the lower index), class_value=0x00E00.
- All entries negative: -1.0 (0xFFC00) except entry 5=-0.5 (0xFFE00) -> class_index=5, class_value=0xFFE00. Signed compare is checked.
- Assert reset at E0+150, release it, then restart -> all outputs 0 during reset; second scan gives the correct result at its own E0'+400.
- READ_LATENCY=1, NEURON=1, entry 0=0x00400 -> done at E0+3, class_index=0, dense_output_enable low after done.
- ARGMAX_TOP2_EN, entries 10=2.0, 20=3.0, 30=2.5, others 0 -> class_index=20, second_index=30, second_value=0x00A00.
